// File: rtl/iter_alu_if.sv
// iter_alu_if: issue/writeback valid-ready bundle plus kill for iter_alu
interface iter_alu_if #(parameter int WIDTH = 32, parameter int OPW = 5);
  logic in_valid, in_ready, kill, out_valid, out_ready, negative, zero, overflow;
  logic [OPW-1:0] op;
  logic [WIDTH-1:0] port_a, port_b, port_out;
  modport master(output in_valid, op, port_a, port_b, kill, out_ready,
                 input in_ready, out_valid, port_out, negative, zero, overflow);
  modport slave(input in_valid, op, port_a, port_b, kill, out_ready,
                output in_ready, out_valid, port_out, negative, zero, overflow);
endinterface

// File: rtl/iter_alu.sv
// iter_alu: EX-stage unit, 1-cycle base ops and bit-serial RV32M multiply/divide
module iter_alu #(parameter int WIDTH = 32, parameter int OPW = 5) (
  input logic CLK,
  input logic RST,
  iter_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] pa, pb, sum, dif, base, ma, mb, min_v, mul_hi, mul_lo, div_hi, div_lo, quo, rem;
  logic [WIDTH:0] add_b, shifted, trial;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [SW-1:0] sh;
  logic accept, is_md, is_div, sgn_a, sgn_b, sa, sb, div0, dovf, base_ovf;
  assign pa = bus.port_a;
  assign pb = bus.port_b;
  assign sh = pb[SW-1:0];
  assign sum = pa + pb;
  assign dif = pa - pb;
  assign min_v = {1'b1, {(WIDTH-1){1'b0}}};
  assign accept = bus.in_valid && state_q == IDLE && !bus.kill;
  assign is_md = bus.op >= OPW'(16) && bus.op <= OPW'(23);
  assign is_div = is_md && bus.op >= OPW'(20);
  assign sgn_a = bus.op == OPW'(17) || bus.op == OPW'(18) || bus.op == OPW'(20) || bus.op == OPW'(22);
  assign sgn_b = bus.op == OPW'(17) || bus.op == OPW'(20) || bus.op == OPW'(22);
  assign sa = sgn_a && pa[WIDTH-1];
  assign sb = sgn_b && pb[WIDTH-1];
  assign ma = sa ? -pa : pa;
  assign mb = sb ? -pb : pb;
  assign div0 = pb == '0;
  assign dovf = !bus.op[0] && pa == min_v && pb == '1;
  // multiply: {hi,a} is the running product, a starts as the multiplier
  assign add_b = {1'b0, hi_q} + {1'b0, b_q & {WIDTH{a_q[0]}}};
  assign mul_hi = add_b[WIDTH:1];
  assign mul_lo = {add_b[0], a_q[WIDTH-1:1]};
  assign prod = {mul_hi, mul_lo};
  assign prod_s = neg_q ? -prod : prod;
  // divide: hi is the partial remainder, a shifts dividend out and quotient in
  assign shifted = {hi_q, a_q[WIDTH-1]};
  assign trial = shifted - {1'b0, b_q};
  assign div_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign div_lo = {a_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quo = neg_q ? -div_lo : div_lo;
  assign rem = neg_q ? -div_hi : div_hi;
  always_comb begin
    base = '0;
    base_ovf = 1'b0;
    case (bus.op)
      OPW'(0): begin
        base = sum;
        base_ovf = pa[WIDTH-1] == pb[WIDTH-1] && sum[WIDTH-1] != pa[WIDTH-1];
      end
      OPW'(1): begin
        base = dif;
        base_ovf = pa[WIDTH-1] != pb[WIDTH-1] && dif[WIDTH-1] != pa[WIDTH-1];
      end
      OPW'(2): base = pa << sh;
      OPW'(3): base = pa >> sh;
      OPW'(4): base = $signed(pa) >>> sh;
      OPW'(5): base = pa & pb;
      OPW'(6): base = pa | pb;
      OPW'(7): base = pa ^ pb;
      OPW'(8): base = {{(WIDTH-1){1'b0}}, $signed(pa) < $signed(pb)};
      OPW'(9): base = {{(WIDTH-1){1'b0}}, pa < pb};
      default: base = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    res_d = res_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = bus.op;
        a_d = ma;
        b_d = mb;
        hi_d = '0;
        cnt_d = CW'(WIDTH);
        neg_d = bus.op == OPW'(22) ? sa : sa ^ sb;
        res_d = base;
        ovf_d = base_ovf;
        state_d = !is_md ? DONE : !is_div ? MUL : (div0 || dovf) ? DONE : DIV;
        if (is_div && div0) res_d = bus.op[1] ? pa : '1;
        else if (is_div && dovf) begin
          res_d = bus.op[1] ? '0 : min_v;
          ovf_d = 1'b1;
        end
      end
      MUL: begin
        hi_d = mul_hi;
        a_d = mul_lo;
        cnt_d = cnt_q - 1'b1;
        res_d = cnt_q == CW'(1) ? (op_q == OPW'(16) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]) : res_q;
        state_d = cnt_q == CW'(1) ? DONE : MUL;
      end
      DIV: begin
        hi_d = div_hi;
        a_d = div_lo;
        cnt_d = cnt_q - 1'b1;
        res_d = cnt_q == CW'(1) ? (op_q[1] ? rem : quo) : res_q;
        state_d = cnt_q == CW'(1) ? DONE : DIV;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (bus.kill && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.port_out = res_q;
  assign bus.negative = res_q[WIDTH-1];
  assign bus.zero = res_q == '0;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: random and directed checks of iter_alu against an arithmetic reference model
module tb_iter_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  iter_alu_if #(.WIDTH(32), .OPW(5)) bus();
  iter_alu #(.WIDTH(32), .OPW(5)) dut(.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output int lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    logic [63:0] p;
    bit mn1 = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    r = '0;
    o = 1'b0;
    lat = 1;
    case (op)
      5'd0: begin r = a + b; o = (sa + sb) != longint'($signed(r)); end
      5'd1: begin r = a - b; o = (sa - sb) != longint'($signed(r)); end
      5'd2: r = a << b[4:0];
      5'd3: r = a >> b[4:0];
      5'd4: r = $signed(a) >>> b[4:0];
      5'd5: r = a & b;
      5'd6: r = a | b;
      5'd7: r = a ^ b;
      5'd8: r = {31'b0, sa < sb};
      5'd9: r = {31'b0, ua < ub};
      5'd16: begin p = ua * ub; r = p[31:0]; lat = 33; end
      5'd17: begin p = sa * sb; r = p[63:32]; lat = 33; end
      5'd18: begin p = sa * ub; r = p[63:32]; lat = 33; end
      5'd19: begin p = ua * ub; r = p[63:32]; lat = 33; end
      5'd20: if (b == 0) r = '1; else if (mn1) begin r = 32'h8000_0000; o = 1'b1; end
             else begin p = sa / sb; r = p[31:0]; lat = 33; end
      5'd21: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; lat = 33; end
      5'd22: if (b == 0) r = a; else if (mn1) begin r = '0; o = 1'b1; end
             else begin p = sa % sb; r = p[31:0]; lat = 33; end
      5'd23: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; lat = 33; end
      default: r = '0;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.port_a = a;
    bus.port_b = b;
    tick();
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom);
    bus.port_a = $urandom;
    bus.port_b = $urandom;
  endtask
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic eo;
    int el;
    int n = 1;
    model(op, a, b, er, eo, el);
    issue(op, a, b);
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    chk($sformatf("lat op%0d", op), n, el);
    chk($sformatf("res op%0d %h %h", op, a, b), bus.port_out, er);
    chk($sformatf("ovf op%0d", op), bus.overflow, eo);
    chk("neg", bus.negative, er[31]);
    chk("zero", bus.zero, er == 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_ready", bus.in_ready, 0);
      chk("hold_res", bus.port_out, er);
      chk("hold_ovf", bus.overflow, eo);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("back_idle", bus.in_ready, 1);
    chk("back_valid", bus.out_valid, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 9));
      5: return -32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int ops[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21, 22, 23, 12, 30};
    bit seen;
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.port_a = '0;
    bus.port_b = '0;
    repeat (2) tick();
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_out", bus.port_out, 0);
    chk("rst_flags", {bus.negative, bus.zero, bus.overflow}, 3'b010);
    rst = 1'b0;
    tick();
    run(5'd0, 32'h7FFF_FFFF, 32'h1, 0);
    run(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(5'd20, -32'd7, 32'd2, 0);
    run(5'd22, -32'd7, 32'd2, 0);
    run(5'd21, 32'd7, 32'd0, 0);
    run(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(5'd4, 32'h8000_00F0, 32'h0000_0124, 0);
    run(5'd1, 32'h8000_0000, 32'h1, 5);
    run(5'd13, 32'h1234, 32'h5678, 0);
    issue(5'd21, $urandom, 32'd7);
    repeat (9) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= bus.out_valid;
    end
    chk("kill_silent", seen, 0);
    run(5'd0, 32'd2, 32'd3, 0);
    bus.in_valid = 1'b1;
    bus.kill = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    chk("kill_idle_valid", bus.out_valid, 0);
    chk("kill_idle_ready", bus.in_ready, 1);
    issue(5'd0, 32'd1, 32'd1);
    bus.kill = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.kill = 1'b0;
    bus.out_ready = 1'b0;
    chk("kill_done_valid", bus.out_valid, 0);
    issue(5'd16, 32'd3, 32'd5);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_out", bus.port_out, 0);
    for (int i = 0; i < 80; i++)
      run(5'(ops[$urandom_range(0, 19)]), pick(), pick(), int'($urandom_range(0, 2)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
